// File: rtl/cnt_arb_ctrl_pkg.sv
// Shared types and constants for the cnt_arb_ctrl counter controller/arbiter.
package definitions_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int N_REQ     = 2;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cnt_arb_state_e;
endpackage

// File: rtl/cnt_arb_ctrl_if.sv
// Bundle of requester job handshake, completion and counter_ud drive signals.
interface cnt_arb_if #(parameter int CNT_W = definitions_pkg::CNT_W_DEF);
  import definitions_pkg::*;

  // Handshake: requester i raises req_valid[i] with start/down/len stable and
  // holds them until req_ready[i] is high; the job transfers on the rising
  // edge where both are high. done[i] is a one-cycle pulse, no back-pressure.
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][CNT_W-1:0] req_start;
  logic [N_REQ-1:0]            req_down;
  logic [N_REQ-1:0][CNT_W-1:0] req_len;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            done;
  logic [CNT_W-1:0]            result;
  logic [CNT_W-1:0]            wraps;
  logic [CNT_W-1:0]            cnt_load;
  logic                        cnt_load_en;
  logic                        cnt_down;
  logic [CNT_W-1:0]            cnt_count;

  modport slave (
    input  req_valid, req_start, req_down, req_len, cnt_count,
    output req_ready, done, result, wraps, cnt_load, cnt_load_en, cnt_down
  );

  modport master (
    output req_valid, req_start, req_down, req_len, cnt_count,
    input  req_ready, done, result, wraps, cnt_load, cnt_load_en, cnt_down
  );
endinterface

// File: rtl/cnt_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end
endmodule

// File: rtl/cnt_arb_ctrl.sv
// Job controller for a shared counter_ud with two round-robin requesters.
// Optional wrap counting is built when CNT_ARB_WRAP_CNT_EN is defined.
module cnt_arb_ctrl
  import definitions_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  cnt_arb_if.slave       bus,
  output cnt_arb_state_e dbg_state
);
  cnt_arb_state_e   state, state_nxt;
  logic             rst_done;
  logic [1:0]       grant;
  logic             accept;
  logic             job_id;
  logic [CNT_W-1:0] job_start, job_len, rem;
  logic             job_down;
  logic [CNT_W-1:0] cnt_load, count_nxt;
  logic             cnt_load_en, cnt_down;
  logic [1:0]       done_q;
  logic [CNT_W-1:0] result_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .valid  (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.req_ready = (state == IDLE && rst_done) ? grant : 2'b00;
  assign accept        = |bus.req_ready;

  // Idle/done hold the counter by reloading its own value.
  always_comb begin
    state_nxt   = state;
    cnt_load    = bus.cnt_count;
    cnt_load_en = 1'b1;
    cnt_down    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        cnt_load  = job_start;
        cnt_down  = job_down;
        state_nxt = (job_len == '0) ? DONE : RUN;
      end
      RUN: begin
        cnt_load_en = 1'b0;
        cnt_load    = '0;
        cnt_down    = job_down;
        if (rem == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Value the counter takes at this edge; registered into result on entry to DONE.
  assign count_nxt = cnt_load_en ? cnt_load :
                     (cnt_down ? bus.cnt_count - 1'b1 : bus.cnt_count + 1'b1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rst_done  <= 1'b0;
      job_id    <= 1'b0;
      job_start <= '0;
      job_down  <= 1'b0;
      job_len   <= '0;
      rem       <= '0;
      done_q    <= 2'b00;
      result_q  <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      done_q   <= 2'b00;
      if (accept) begin
        job_id    <= grant[1];
        job_start <= bus.req_start[grant[1]];
        job_down  <= bus.req_down[grant[1]];
        job_len   <= bus.req_len[grant[1]];
      end
      if (state == LOAD) rem <= job_len;
      else if (state == RUN) rem <= rem - 1'b1;
      if (state_nxt == DONE) begin
        done_q   <= job_id ? 2'b10 : 2'b01;
        result_q <= count_nxt;
      end
    end
  end

`ifdef CNT_ARB_WRAP_CNT_EN
  logic [CNT_W-1:0] wrap_cnt, wrap_nxt, wraps_q;
  logic             wrap_hit;

  // A step out of all-ones (up) or zero (down) wraps; the count saturates.
  always_comb begin
    wrap_nxt = wrap_cnt;
    wrap_hit = (!job_down && bus.cnt_count == '1) || (job_down && bus.cnt_count == '0);
    if (state == LOAD) wrap_nxt = '0;
    else if (state == RUN && wrap_hit && wrap_cnt != '1) wrap_nxt = wrap_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap_cnt <= '0;
      wraps_q  <= '0;
    end else begin
      wrap_cnt <= wrap_nxt;
      if (state_nxt == DONE) wraps_q <= wrap_nxt;
    end
  end

  assign bus.wraps = wraps_q;
`else
  assign bus.wraps = '0;
`endif

  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.cnt_load    = cnt_load;
  assign bus.cnt_load_en = cnt_load_en;
  assign bus.cnt_down    = cnt_down;
  assign dbg_state       = state;
endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Directed bench for cnt_arb_ctrl with a behavioural counter_ud model attached.
module tb_cnt_arb_ctrl;
  import definitions_pkg::*;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  cnt_arb_state_e dbg_state;
  logic [3:0]     cnt_model;
  int             n_checks = 0;
  int             n_err = 0;

  cnt_arb_if #(.CNT_W(4)) bus ();

  cnt_arb_ctrl #(.CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // counter_ud model: steps every clock unless loaded
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_model <= 4'h0;
    else if (bus.cnt_load_en) cnt_model <= bus.cnt_load;
    else if (bus.cnt_down) cnt_model <= cnt_model - 4'h1;
    else cnt_model <= cnt_model + 4'h1;
  end
  assign bus.cnt_count = cnt_model;

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_wraps(input logic [3:0] w);
`ifdef CNT_ARB_WRAP_CNT_EN
    return w;
`else
    return 4'h0 & w;
`endif
  endfunction

  always @(negedge clk) begin
    #1;
    if (rstn && bus.req_ready != 2'b00) check("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
    if (rstn && bus.done != 2'b00) check("done_onehot", 32'($countones(bus.done)), 32'd1);
  end

  // ---- drivers ----
  task automatic set_req(input int id, input logic [3:0] start, input logic down, input logic [3:0] len);
    bus.req_start[id] = start;
    bus.req_down[id]  = down;
    bus.req_len[id]   = len;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_ready(input string tag, output logic [1:0] got);
    int n = 0;
    #1;
    while (bus.req_ready == 2'b00 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    got = bus.req_ready;
  endtask

  // Called in the accept cycle; checks latency, done and result.
  task automatic finish_job(input string tag, input int id, input logic [3:0] len,
                            input logic [3:0] exp_res, input logic [3:0] exp_w);
    int lat = 1;
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    #1;
    while (bus.done == 2'b00 && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(len) + 32'd2);
    check({tag, "_done"}, 32'(bus.done), (id == 1) ? 32'd2 : 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_wraps"}, 32'(bus.wraps), 32'(exp_wraps(exp_w)));
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_job(input string tag, input int id, input logic [3:0] start, input logic down,
                         input logic [3:0] len, input logic [3:0] exp_res, input logic [3:0] exp_w);
    logic [1:0] got;
    set_req(id, start, down, len);
    wait_ready(tag, got);
    check({tag, "_grant"}, 32'(got), (id == 1) ? 32'd2 : 32'd1);
    finish_job(tag, id, len, exp_res, exp_w);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_wraps"}, 32'(bus.wraps), 32'd0);
    check({tag, "_load_en"}, 32'(bus.cnt_load_en), 32'd1);
    check({tag, "_down"}, 32'(bus.cnt_down), 32'd0);
    check({tag, "_load"}, 32'(bus.cnt_load), 32'(cnt_model));
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---- stimulus ----
  initial begin
    logic [1:0] got;
    int         seen_done;
    bus.req_valid = 2'b00;
    bus.req_start = '0;
    bus.req_down  = 2'b00;
    bus.req_len   = '0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_values("rst");

    // 1: request held through reset; grant only once rst_done is set
    set_req(0, 4'h3, 1'b0, 4'd4);
    @(negedge clk); #1;
    check("rst_hold_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("release_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); #1;
    check("first_idle_ready", 32'(bus.req_ready), 32'd1);
    finish_job("up4", 0, 4'd4, 4'h7, 4'h0);

    // 2: down count through zero
    run_job("dn5", 1, 4'h2, 1'b1, 4'd5, 4'hD, 4'h1);

    // 3: both valid together, requester 0 first
    @(negedge clk);
    set_req(0, 4'h1, 1'b0, 4'd2);
    set_req(1, 4'h8, 1'b0, 4'd2);
    wait_ready("both", got);
    check("both_first_grant", 32'(got), 32'd1);
    finish_job("both0", 0, 4'd2, 4'h3, 4'h0);
    wait_ready("both", got);
    check("both_second_grant", 32'(got), 32'd2);
    finish_job("both1", 1, 4'd2, 4'hA, 4'h0);

    // 4: zero-length job, then counter must hold
    run_job("len0", 0, 4'hF, 1'b0, 4'd0, 4'hF, 4'h0);
    for (int i = 0; i < 10; i++) begin
      check("idle_hold", 32'(cnt_model), 32'hF);
      @(negedge clk); #1;
    end

    // 5: up count through all-ones
    run_job("upwrap", 1, 4'hE, 1'b0, 4'd3, 4'h1, 4'h1);

    // 6: reset in the middle of RUN abandons the job
    @(negedge clk);
    set_req(1, 4'h9, 1'b0, 4'd10);
    wait_ready("mid", got);
    check("mid_grant", 32'(got), 32'd2);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_in_run", 32'(dbg_state), 32'(RUN));
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.done != 2'b00) seen_done++;
    end
    check("mid_no_done", 32'(seen_done), 32'd0);
    run_job("reissue", 1, 4'h9, 1'b0, 4'd10, 4'h3, 4'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/cnt_arb_ctrl.md
# cnt_arb_ctrl

Controller and two-requester round-robin arbiter for the shared `counter_ud` up/down counter. Each requester asks for one counting job: a start value, a direction and a step count. The block grants one job at a time and drives the counter's `load`/`load_en`/`down` inputs to preload and then step the counter exactly that many times. It freezes the counter between jobs and returns the final count to the winner with a one-cycle `done` pulse.

## Interface
- `CNT_W`, default 4: counter width; must equal the `counter_ud` count width.
- `clk`  in  1  system clock, all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  2  per-requester job request; held high with fields stable until accepted.
- `req_start`  in  2×CNT_W  per-requester preload value.
- `req_down`  in  2  per-requester direction, 1 = count down.
- `req_len`  in  2×CNT_W  per-requester step count, 0..2^CNT_W−1.
- `req_ready`  out  2  one-hot accept strobe, one cycle.
- `done`  out  2  one-hot job-complete pulse, one cycle.
- `result`  out  CNT_W  final count, valid while `done` is nonzero.
- `wraps`  out  CNT_W  number of wrap-arounds in the last job (see Configuration).
- `cnt_load`  out  CNT_W  to `counter_ud.load`.
- `cnt_load_en`  out  1  to `counter_ud.load_en`.
- `cnt_down`  out  1  to `counter_ud.down`.
- `cnt_count`  in  CNT_W  from `counter_ud.count`.

## Operation
- Hold rule: `counter_ud` steps every clock unless loaded. The block therefore freezes the counter by driving `cnt_load_en=1` with `cnt_load=cnt_count`.
- FSM states:
  - IDLE (reset state): hold the counter. If `rst_done` is set and any `req_valid` is high, assert `req_ready[g]` for winner g. Latch start, down and len for g, then go to LOAD.
  - LOAD: drive `cnt_load_en=1`, `cnt_load=start`, `cnt_down=down`. Set remaining=len. If len==0, go to DONE; otherwise go to RUN.
  - RUN: drive `cnt_load_en=0`, `cnt_down=down`, `cnt_load=0`. Decrement remaining each cycle. Go to DONE in the cycle where remaining==1.
  - DONE: hold the counter. Drive `done[g]=1` and `result=cnt_count`. Return to IDLE.
- Arbitration:
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester pointed to by the round-robin pointer (reset value 0).
  - On every grant, set the pointer to the other requester.
- A request arriving mid-job waits until IDLE; it is never dropped.
- `rst_done`: a flag register cleared by reset and set on the first edge after reset release. `req_ready` stays 0 until it is set.
- Width: all count arithmetic is modulo 2^CNT_W. `result = (start ± len) mod 2^CNT_W`.
- Reset mid-job: the FSM returns to IDLE immediately and the job is abandoned; no `done` is issued. The requester must re-request.

## Timing
- Reset values:
  - `req_ready=0`, `done=0`, `result=0`, `wraps=0`.
  - `cnt_load_en=1`, `cnt_down=0`, `cnt_load=cnt_count`.
- `cnt_*` outputs are combinational from the state and latched job registers.
- `req_ready` is combinational from state, `rst_done`, `req_valid` and the pointer.
- `done`, `result` and `wraps` are registered.
- Cycle map, with acceptance in cycle 0:
  - cycle 1: LOAD.
  - cycles 2..len+1: RUN.
  - cycle len+2: DONE.
  - cycle len+3: IDLE, earliest next accept.
- Job occupancy is len+3 cycles. For len=0, `done` occurs in cycle 2.

## Configuration
- `CNT_ARB_WRAP_CNT_EN` defined:
  - In RUN, a wrap is counted when (!down && cnt_count==all-ones) or (down && cnt_count==0).
  - The wrap counter clears in LOAD and saturates at all-ones.
  - `wraps` is registered with `result` in DONE and holds until the next DONE.
- Not defined: `wraps` is constant 0 and no wrap logic is built.

## Structure
- `definitions_pkg` holds:
  - `CNT_W_DEF=4` and `N_REQ=2`;
  - `typedef logic [CNT_W_DEF-1:0] cnt_t`;
  - `typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cnt_arb_state_e`.
- Sub-module `rr_arb2` holds the 2-way round-robin arbiter: valid in, one-hot grant out, pointer update on accept.

## Test plan
- Reset release, requester 0 with start=0x3, down=0, len=4: `req_ready[0]` in the first IDLE cycle after `rst_done`; `done[0]` 6 cycles later with `result`=0x7.
- Requester 1 with start=0x2, down=1, len=5: `result`=0xD; with the macro defined, `wraps`=1.
- Both valid at once with start 0x1/0x8, len 2: requester 0 is granted first, then requester 1. Expect `done[0]` `result`=0x3, then `done[1]` `result`=0xA. No cycle ever has two bits of `req_ready` set.
- len=0, start=0xF: `done` 2 cycles after accept with `result`=0xF. The counter holds at 0xF in IDLE for 10 cycles afterwards.
- Up count from start=0xE, len=3 with the macro defined: `result`=0x1, `wraps`=1. With the macro undefined: `wraps`=0.
- `rstn` pulsed low during RUN of a len=10 job: outputs go to reset values at once and no `done` is issued. After release, the re-issued request completes normally.
